// File: rtl/ldpc_pkg.sv
// Shared encodings and default geometry for the LDPC input frame scheduler.
package ldpc_pkg;

    localparam int D_WID_DEF    = 6;
    localparam int FRM_LEN_DEF  = 9216;
    localparam int ADDR_WID_DEF = 14;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DEC   = 2'd3
    } bank_st_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_st_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_RUN  = 1'b1
    } dec_st_t;

    // Scheduler control state kept in one struct so it can be observed as a unit.
    typedef struct packed {
        wr_st_t  wr_st;
        dec_st_t dec_st;
        logic    order;
    } sched_st_t;

endpackage

// File: rtl/ldpc_bank_state.sv
// Per-bank lifecycle register (EMPTY/FILL/FULL/DEC) with the frame's latched rate and iteration limit.
module ldpc_bank_state
    import ldpc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_fill,
    input  logic       set_full,
    input  logic       set_dec,
    input  logic       clear,
    input  logic       rate,
    input  logic [4:0] max_iter,
    output bank_st_t   state,
    output logic       lat_rate,
    output logic [4:0] lat_max_iter
);

    // The scheduler never raises two strobes for one bank in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= BANK_EMPTY;
            lat_rate     <= 1'b0;
            lat_max_iter <= 5'd0;
        end else if (set_fill) begin
            state        <= BANK_FILL;
            lat_rate     <= rate;
            lat_max_iter <= max_iter;
        end else if (set_full) begin
            state <= BANK_FULL;
        end else if (set_dec) begin
            state <= BANK_DEC;
        end else if (clear) begin
            state <= BANK_EMPTY;
        end
    end

endmodule

// File: rtl/ldpc_frame_sched.sv
// Ping-pong frame scheduler: fills two LLR banks from the sample stream and hands full banks to the decoder.
module ldpc_frame_sched
    import ldpc_pkg::*;
#(
    parameter int D_WID    = D_WID_DEF,
    parameter int FRM_LEN  = FRM_LEN_DEF,
    parameter int ADDR_WID = ADDR_WID_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sync_in,
    input  logic [D_WID-1:0]    data_in,
    input  logic                rate,
    input  logic [4:0]          max_iter,
    output logic                buf_we,
    output logic                buf_bank,
    output logic [ADDR_WID-1:0] buf_waddr,
    output logic [D_WID-1:0]    buf_wdata,
    output logic                dec_start,
    output logic                dec_bank,
    output logic                dec_rate,
    output logic [4:0]          dec_max_iter,
    input  logic                dec_done,
    output logic                busy,
    output logic                frame_drop
);

    // Handshakes: sync_in is valid-only (no backpressure; unaccepted samples are
    // dropped). dec_start is a one-cycle request; dec_bank/rate/max_iter hold
    // until the core answers with a one-cycle dec_done, which frees the bank.

    localparam logic [ADDR_WID-1:0] LAST_ADDR = ADDR_WID'(FRM_LEN - 1);

    sched_st_t                st, st_n;
    logic [ADDR_WID-1:0]      waddr, waddr_n;
    logic                     fill_bank, fill_bank_n;

    bank_st_t [1:0]           bank_st;
    logic [1:0]               lat_rate;
    logic [1:0][4:0]          lat_iter;
    logic [1:0]               set_fill, set_full, set_dec, abort_clr, done_clr;
    logic [1:0]               bank_full;
    logic                     any_empty, fill_tgt, dec_pick;

    logic                     buf_we_n, buf_bank_n, frame_drop_n;
    logic [ADDR_WID-1:0]      buf_waddr_n;
    logic                     dec_start_n, dec_bank_n, dec_rate_n;
    logic [4:0]               dec_iter_n;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ldpc_bank_state u_bank (
            .clk          (clk),
            .reset_n      (reset_n),
            .set_fill     (set_fill[g]),
            .set_full     (set_full[g]),
            .set_dec      (set_dec[g]),
            .clear        (abort_clr[g] | done_clr[g]),
            .rate         (rate),
            .max_iter     (max_iter),
            .state        (bank_st[g]),
            .lat_rate     (lat_rate[g]),
            .lat_max_iter (lat_iter[g])
        );
        assign bank_full[g] = (bank_st[g] == BANK_FULL);
    end

    assign any_empty = (bank_st[0] == BANK_EMPTY) || (bank_st[1] == BANK_EMPTY);
    assign fill_tgt  = (bank_st[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    // order holds the bank that became FULL most recently, so the other one is older.
    assign dec_pick  = (bank_full == 2'b11) ? ~st.order : bank_full[1];
    assign busy      = (bank_st[0] != BANK_EMPTY) || (bank_st[1] != BANK_EMPTY);

    always_comb begin
        st_n         = st;
        waddr_n      = waddr;
        fill_bank_n  = fill_bank;
        set_fill     = '0;
        set_full     = '0;
        set_dec      = '0;
        abort_clr    = '0;
        done_clr     = '0;
        buf_we_n     = 1'b0;
        buf_bank_n   = buf_bank;
        buf_waddr_n  = buf_waddr;
        frame_drop_n = 1'b0;
        dec_start_n  = 1'b0;
        dec_bank_n   = dec_bank;
        dec_rate_n   = dec_rate;
        dec_iter_n   = dec_max_iter;

        case (st.wr_st)
            W_IDLE: begin
                if (sync_in) begin
                    if (any_empty) begin
                        set_fill[fill_tgt] = 1'b1;
                        fill_bank_n        = fill_tgt;
                        buf_we_n           = 1'b1;
                        buf_bank_n         = fill_tgt;
                        buf_waddr_n        = '0;
                        waddr_n            = ADDR_WID'(1);
                        st_n.wr_st         = W_FILL;
                    end else begin
                        st_n.wr_st = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (sync_in) begin
                    buf_we_n    = 1'b1;
                    buf_bank_n  = fill_bank;
                    buf_waddr_n = waddr;
                    if (waddr == LAST_ADDR) begin
                        set_full[fill_bank] = 1'b1;
                        st_n.order          = fill_bank;
                        waddr_n             = '0;
                        st_n.wr_st          = W_IDLE;
                    end else begin
                        waddr_n = waddr + 1'b1;
                    end
                end else begin
                    abort_clr[fill_bank] = 1'b1;
                    frame_drop_n         = 1'b1;
                    waddr_n              = '0;
                    st_n.wr_st           = W_IDLE;
                end
            end
            W_DROP: begin
                if (!sync_in) begin
                    frame_drop_n = 1'b1;
                    st_n.wr_st   = W_IDLE;
                end
            end
            default: st_n.wr_st = W_IDLE;
        endcase

        if (st.dec_st == D_IDLE) begin
            if (bank_full != 2'b00) begin
                set_dec[dec_pick] = 1'b1;
                dec_start_n       = 1'b1;
                dec_bank_n        = dec_pick;
                dec_rate_n        = lat_rate[dec_pick];
                dec_iter_n        = lat_iter[dec_pick];
                st_n.dec_st       = D_RUN;
            end
        end else if (dec_done) begin
            done_clr[dec_bank] = 1'b1;
            st_n.dec_st        = D_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st           <= '{wr_st: W_IDLE, dec_st: D_IDLE, order: 1'b0};
            waddr        <= '0;
            fill_bank    <= 1'b0;
            buf_we       <= 1'b0;
            buf_bank     <= 1'b0;
            buf_waddr    <= '0;
            buf_wdata    <= '0;
            frame_drop   <= 1'b0;
            dec_start    <= 1'b0;
            dec_bank     <= 1'b0;
            dec_rate     <= 1'b0;
            dec_max_iter <= 5'd0;
        end else begin
            st           <= st_n;
            waddr        <= waddr_n;
            fill_bank    <= fill_bank_n;
            buf_we       <= buf_we_n;
            buf_bank     <= buf_bank_n;
            buf_waddr    <= buf_waddr_n;
            if (buf_we_n) begin
                buf_wdata <= data_in;
            end
            frame_drop   <= frame_drop_n;
            dec_start    <= dec_start_n;
            dec_bank     <= dec_bank_n;
            dec_rate     <= dec_rate_n;
            dec_max_iter <= dec_iter_n;
        end
    end

endmodule
